alu_issuer: RTL and testbench
=============================

ALU_ISSUER -- requirements
Module: alu_issuer

Interface
REQ-001 SHALL have parameter LAT, default 1, meaning ALU settle cycles between driving operands and capturing results (legal range 1..15).
REQ-002 SHALL have one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req_valid  input  1  operation request present.
REQ-005 req_ready  output  1  issuer can accept a request.
REQ-006 req_op  input  4  opcode: 0000 AND, 0010 SUB, 0100 ADD, 0101 ADC; others pass through.
REQ-007 req_a, req_b  input  32 each  operands.
REQ-008 req_cin  input  1  carry-in for non-ADC opcodes.
REQ-009 req_setflags  input  1  update NZCV on completion.
REQ-010 alu_a, alu_b  output  32 each  ALU operand drive.
REQ-011 alu_op  output  4  ALU opcode drive; alu_cin  output  1  ALU carry-in drive.
REQ-012 alu_result  input  32; alu_cout  input  1; alu_zero  input  1  ALU outputs, combinational from alu_* drives.
REQ-013 rsp_valid  output  1; rsp_ready  input  1  response handshake.
REQ-014 rsp_result  output  32  captured result; flags  output  4  {N,Z,C,V} register.

Function
REQ-015 SHALL implement FSM states IDLE, DRIVE and RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 Accept on a rising edge with req_valid=1 and req_ready=1: register req_a/req_b/req_op onto alu_a/alu_b/alu_op; load a settle counter with LAT; go to DRIVE.
REQ-017 alu_cin SHALL be registered as flags.C when req_op=0101, else as req_cin.
REQ-018 alu_* outputs SHALL hold their values from acceptance until the next acceptance.
REQ-019 DRIVE SHALL decrement the counter on every edge. On the edge where the counter reaches 0, the block SHALL capture alu_result into rsp_result, set rsp_valid=1 and go to RESP; rsp_valid therefore rises LAT edges after acceptance.
REQ-020 When setflags was 1 at acceptance, flags SHALL update on the capture edge: N=alu_result[31], Z=alu_zero, C=alu_cout.
REQ-021 On the same capture edge, V SHALL update as follows: ADD/ADC V=(a31==b31)&&(r31!=a31); SUB V=(a31!=b31)&&(r31!=a31); other opcodes leave V unchanged.
REQ-022 setflags=0 SHALL leave all four flags unchanged.
REQ-023 In RESP, rsp_valid and rsp_result SHALL be held stable until an edge with rsp_ready=1, which clears rsp_valid and returns to IDLE.
REQ-024 Back-to-back operation: with LAT=1 and both valids/readies held high, SHALL accept one request every 3 cycles; a request present during DRIVE or RESP SHALL wait and is not lost.
REQ-025 An ADC accepted right after a flag-setting op SHALL use the C flag written by that op.
REQ-026 rsp_ready=1 outside RESP SHALL be ignored.

Reset
REQ-027 While rst_n=0, regardless of clk: state IDLE, counter 0, alu_a/alu_b/rsp_result=0, alu_op=0000, alu_cin=0, rsp_valid=0, flags=0000; req_ready=1 once rst_n=1.
REQ-028 Reset asserted in DRIVE or RESP SHALL abort the operation; no response and no flag update SHALL follow after release.

Verification
REQ-029 LAT=1, ADD a=10 b=10 setflags=1, rsp_ready=1 -> rsp_valid 1 edge after accept, rsp_result=20, flags=0000.
REQ-030 SUB a=10 b=10 cin=1 setflags=1, ALU model cout=1 -> rsp_result=0, flags=0110 (Z,C).
REQ-031 ADD a=0x7FFFFFFF b=1 setflags=1 -> rsp_result=0x80000000, flags N=1 V=1 Z=0 C=0; then AND a=6 b=4 setflags=0 -> rsp_result=4, flags unchanged.
REQ-032 Set C=1, then ADC a=20 b=30 req_cin=0 -> alu_cin=1, rsp_result=51.
REQ-033 LAT=3, rsp_ready low 4 cycles after rsp_valid -> rsp_valid rises exactly 3 edges after accept; rsp_result stable; req_ready=0 throughout; a second queued request is accepted only after the rsp handshake.
REQ-034 rst_n pulsed low during DRIVE -> all outputs at reset values immediately; no rsp_valid after release; req_ready=1.

Source files
------------

// File: rtl/alu_issuer.sv
// Issues one ALU operation at a time: registers the operands onto the ALU drive,
// waits LAT settle cycles, captures the result and NZCV flags, then handshakes the response.
module alu_issuer #(
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        req_cin,
    input  logic        req_setflags,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    output logic        alu_cin,
    input  logic [31:0] alu_result,
    input  logic        alu_cout,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [3:0]  flags
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] LAT_L  = 4'(LAT);

    typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [3:0]  alu_op_q, alu_op_d;
    logic        alu_cin_q, alu_cin_d;
    logic        setflags_q, setflags_d;
    logic [31:0] rsp_result_q, rsp_result_d;
    logic [3:0]  flags_q, flags_d;
    logic        v_add, v_sub;

    // Overflow is judged against the operands actually driven onto the ALU.
    assign v_add = (alu_a_q[31] == alu_b_q[31]) && (alu_result[31] != alu_a_q[31]);
    assign v_sub = (alu_a_q[31] != alu_b_q[31]) && (alu_result[31] != alu_a_q[31]);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        alu_cin_d    = alu_cin_q;
        setflags_d   = setflags_q;
        rsp_result_d = rsp_result_q;
        flags_d      = flags_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    alu_a_d    = req_a;
                    alu_b_d    = req_b;
                    alu_op_d   = req_op;
                    alu_cin_d  = (req_op == OP_ADC) ? flags_q[1] : req_cin;
                    setflags_d = req_setflags;
                    cnt_d      = LAT_L;
                    state_d    = DRIVE;
                end
            end
            DRIVE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d        = 4'd0;
                    rsp_result_d = alu_result;
                    state_d      = RESP;
                    if (setflags_q) begin
                        flags_d[3] = alu_result[31];
                        flags_d[2] = alu_zero;
                        flags_d[1] = alu_cout;
                        case (alu_op_q)
                            OP_ADD, OP_ADC: flags_d[0] = v_add;
                            OP_SUB:         flags_d[0] = v_sub;
                            default:        flags_d[0] = flags_q[0];
                        endcase
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            alu_a_q      <= 32'd0;
            alu_b_q      <= 32'd0;
            alu_op_q     <= OP_AND;
            alu_cin_q    <= 1'b0;
            setflags_q   <= 1'b0;
            rsp_result_q <= 32'd0;
            flags_q      <= 4'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            alu_cin_q    <= alu_cin_d;
            setflags_q   <= setflags_d;
            rsp_result_q <= rsp_result_d;
            flags_q      <= flags_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign alu_cin    = alu_cin_q;
    assign rsp_result = rsp_result_q;
    assign flags      = flags_q;

endmodule

// File: tb/tb_alu_issuer.sv
// Directed bench for alu_issuer: one instance at LAT=1 and one at LAT=3, each
// wired to a combinational reference ALU.
module tb_alu_issuer;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic        req_valid1, req_ready1, req_cin1, req_setflags1, alu_cin1, alu_cout1, alu_zero1;
    logic        rsp_valid1, rsp_ready1;
    logic [3:0]  req_op1, alu_op1, flags1;
    logic [31:0] req_a1, req_b1, alu_a1, alu_b1, alu_result1, rsp_result1;

    logic        req_valid3, req_ready3, req_cin3, req_setflags3, alu_cin3, alu_cout3, alu_zero3;
    logic        rsp_valid3, rsp_ready3;
    logic [3:0]  req_op3, alu_op3, flags3;
    logic [31:0] req_a3, req_b3, alu_a3, alu_b3, alu_result3, rsp_result3;

    // AND, SUB as a + ~b + cin, ADD/ADC as a + b + cin, anything else passes a.
    function automatic logic [32:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic cin);
        case (op)
            4'b0000:          return {1'b0, a & b};
            4'b0010:          return {1'b0, a} + {1'b0, ~b} + {32'd0, cin};
            4'b0100, 4'b0101: return {1'b0, a} + {1'b0, b} + {32'd0, cin};
            default:          return {1'b0, a};
        endcase
    endfunction

    assign {alu_cout1, alu_result1} = alu_model(alu_op1, alu_a1, alu_b1, alu_cin1);
    assign alu_zero1 = (alu_result1 == 32'd0);
    assign {alu_cout3, alu_result3} = alu_model(alu_op3, alu_a3, alu_b3, alu_cin3);
    assign alu_zero3 = (alu_result3 == 32'd0);

    alu_issuer #(.LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_op(req_op1),
        .req_a(req_a1), .req_b(req_b1), .req_cin(req_cin1), .req_setflags(req_setflags1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1), .alu_cin(alu_cin1),
        .alu_result(alu_result1), .alu_cout(alu_cout1), .alu_zero(alu_zero1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_result(rsp_result1), .flags(flags1)
    );

    alu_issuer #(.LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_op(req_op3),
        .req_a(req_a3), .req_b(req_b3), .req_cin(req_cin3), .req_setflags(req_setflags3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3), .alu_cin(alu_cin3),
        .alu_result(alu_result3), .alu_cout(alu_cout3), .alu_zero(alu_zero3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_result(rsp_result3), .flags(flags3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one request through the LAT=1 instance and returns what it observed.
    task automatic do_op1(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sf, output int lat,
                          output logic [31:0] res, output logic [3:0] flg, output logic cin_seen);
        for (int w = 0; w < 20 && !req_ready1; w++) begin
            @(posedge clk); #1;
        end
        req_op1 = op; req_a1 = a; req_b1 = b; req_cin1 = cin; req_setflags1 = sf;
        req_valid1 = 1'b1;
        @(posedge clk); #1;
        req_valid1 = 1'b0;
        cin_seen = alu_cin1;
        lat = 0;
        while (!rsp_valid1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        res = rsp_result1;
        rsp_ready1 = 1'b1;
        @(posedge clk); #1;
        rsp_ready1 = 1'b0;
        flg = flags1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        checks++;
        if (alu_a1 !== 32'd0 || alu_b1 !== 32'd0 || alu_op1 !== 4'd0 || alu_cin1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_alu: got a=%h b=%h op=%b cin=%b, need all zero", alu_a1, alu_b1, alu_op1, alu_cin1);
        end
        checks++;
        if (rsp_valid1 !== 1'b0 || rsp_result1 !== 32'd0 || flags1 !== 4'd0) begin
            errors++;
            $display("FAIL reset_rsp: got valid=%b result=%h flags=%b, need 0/0/0000", rsp_valid1, rsp_result1, flags1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready1 !== 1'b1 || req_ready3 !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b/%b, need 1/1", req_ready1, req_ready3);
        end
        $display("test_reset: done");
    endtask

    task automatic test_flags;
        int lat; logic [31:0] res; logic [3:0] flg; logic cs;
        do_op1(4'b0100, 32'd10, 32'd10, 1'b0, 1'b1, lat, res, flg, cs);
        checks++;
        if (lat !== 1 || res !== 32'd20 || flg !== 4'b0000) begin
            errors++;
            $display("FAIL add_10_10: got lat=%0d res=%0d flags=%b, need 1/20/0000", lat, res, flg);
        end
        $display("ADD 10+10: lat=%0d res=%0d flags=%b", lat, res, flg);
        do_op1(4'b0010, 32'd10, 32'd10, 1'b1, 1'b1, lat, res, flg, cs);
        checks++;
        if (res !== 32'd0 || flg !== 4'b0110) begin
            errors++;
            $display("FAIL sub_10_10: got res=%0d flags=%b, need 0/0110", res, flg);
        end
        $display("SUB 10-10: res=%0d flags=%b", res, flg);
        do_op1(4'b0100, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1, lat, res, flg, cs);
        checks++;
        if (res !== 32'h8000_0000 || flg !== 4'b1001) begin
            errors++;
            $display("FAIL add_ovf: got res=%h flags=%b, need 80000000/1001", res, flg);
        end
        $display("ADD 7fffffff+1: res=%h flags=%b", res, flg);
        do_op1(4'b0000, 32'd6, 32'd4, 1'b0, 1'b0, lat, res, flg, cs);
        checks++;
        if (res !== 32'd4 || flg !== 4'b1001) begin
            errors++;
            $display("FAIL and_noflags: got res=%0d flags=%b, need 4/1001", res, flg);
        end
        $display("AND 6&4: res=%0d flags=%b", res, flg);
        do_op1(4'b0010, 32'd5, 32'd3, 1'b1, 1'b1, lat, res, flg, cs);
        checks++;
        if (res !== 32'd2 || flg !== 4'b0010) begin
            errors++;
            $display("FAIL sub_set_c: got res=%0d flags=%b, need 2/0010", res, flg);
        end
        $display("SUB 5-3: res=%0d flags=%b", res, flg);
        do_op1(4'b0101, 32'd20, 32'd30, 1'b0, 1'b0, lat, res, flg, cs);
        checks++;
        if (cs !== 1'b1 || res !== 32'd51 || flg !== 4'b0010) begin
            errors++;
            $display("FAIL adc_carry: got cin=%b res=%0d flags=%b, need 1/51/0010", cs, res, flg);
        end
        $display("ADC 20+30+C: cin=%b res=%0d flags=%b", cs, res, flg);
    endtask

    task automatic test_back_to_back;
        int bad_ready = 0, bad_valid = 0, bad_res = 0;
        req_op1 = 4'b0100; req_a1 = 32'd1; req_b1 = 32'd2; req_cin1 = 1'b0; req_setflags1 = 1'b0;
        req_valid1 = 1'b1;
        rsp_ready1 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (req_ready1 !== (i % 3 == 0)) bad_ready++;
            if (rsp_valid1 !== (i % 3 == 2)) bad_valid++;
            if (i % 3 == 2 && rsp_result1 !== 32'd3) bad_res++;
            @(posedge clk); #1;
        end
        req_valid1 = 1'b0;
        rsp_ready1 = 1'b0;
        checks++;
        if (bad_ready != 0 || bad_valid != 0) begin
            errors++;
            $display("FAIL b2b_cadence: got %0d ready and %0d valid cycle errors, need 0/0", bad_ready, bad_valid);
        end
        checks++;
        if (bad_res != 0) begin
            errors++;
            $display("FAIL b2b_result: got %0d wrong results, need 0", bad_res);
        end
        $display("back_to_back: ready_err=%0d valid_err=%0d res_err=%0d", bad_ready, bad_valid, bad_res);
    endtask

    task automatic test_lat3;
        int lat = 0, bad_ready = 0, bad_hold = 0;
        req_op3 = 4'b0010; req_a3 = 32'd100; req_b3 = 32'd1; req_cin3 = 1'b1; req_setflags3 = 1'b1;
        req_valid3 = 1'b1;
        rsp_ready3 = 1'b0;
        @(posedge clk); #1;
        req_op3 = 4'b0100; req_a3 = 32'd7; req_b3 = 32'd8; req_cin3 = 1'b0; req_setflags3 = 1'b0;
        while (!rsp_valid3 && lat < 20) begin
            if (req_ready3 !== 1'b0) bad_ready++;
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 3 || rsp_result3 !== 32'd99 || bad_ready != 0) begin
            errors++;
            $display("FAIL lat3_first: got lat=%0d res=%0d ready_err=%0d, need 3/99/0", lat, rsp_result3, bad_ready);
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (rsp_valid3 !== 1'b1 || rsp_result3 !== 32'd99 || req_ready3 !== 1'b0) bad_hold++;
        end
        checks++;
        if (bad_hold != 0 || alu_a3 !== 32'd100) begin
            errors++;
            $display("FAIL lat3_hold: got %0d unstable cycles alu_a=%0d, need 0/100", bad_hold, alu_a3);
        end
        rsp_ready3 = 1'b1;
        @(posedge clk); #1;
        rsp_ready3 = 1'b0;
        checks++;
        if (rsp_valid3 !== 1'b0 || req_ready3 !== 1'b1 || alu_a3 !== 32'd100 || flags3 !== 4'b0010) begin
            errors++;
            $display("FAIL lat3_handshake: got valid=%b ready=%b alu_a=%0d flags=%b, need 0/1/100/0010",
                     rsp_valid3, req_ready3, alu_a3, flags3);
        end
        @(posedge clk); #1;
        req_valid3 = 1'b0;
        checks++;
        if (alu_a3 !== 32'd7 || req_ready3 !== 1'b0) begin
            errors++;
            $display("FAIL lat3_queued_accept: got alu_a=%0d ready=%b, need 7/0", alu_a3, req_ready3);
        end
        lat = 0;
        while (!rsp_valid3 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 3 || rsp_result3 !== 32'd15) begin
            errors++;
            $display("FAIL lat3_second: got lat=%0d res=%0d, need 3/15", lat, rsp_result3);
        end
        rsp_ready3 = 1'b1;
        @(posedge clk); #1;
        rsp_ready3 = 1'b0;
        $display("lat3: second response res=%0d lat=%0d", rsp_result3, lat);
    endtask

    task automatic test_reset_abort;
        int seen = 0;
        req_op3 = 4'b0100; req_a3 = 32'h7FFF_FFFF; req_b3 = 32'd1; req_cin3 = 1'b0; req_setflags3 = 1'b1;
        req_valid3 = 1'b1;
        @(posedge clk); #1;
        req_valid3 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (alu_a3 !== 32'd0 || alu_op3 !== 4'd0 || rsp_valid3 !== 1'b0 || req_ready3 !== 1'b1 ||
            flags3 !== 4'd0 || flags1 !== 4'd0) begin
            errors++;
            $display("FAIL abort_immediate: got alu_a=%h op=%b valid=%b ready=%b flags=%b/%b, need 0/0000/0/1/0000/0000",
                     alu_a3, alu_op3, rsp_valid3, req_ready3, flags3, flags1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (rsp_valid3 !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0 || flags3 !== 4'd0 || req_ready3 !== 1'b1) begin
            errors++;
            $display("FAIL abort_after: got %0d valid cycles flags=%b ready=%b, need 0/0000/1", seen, flags3, req_ready3);
        end
        $display("reset_abort: valid cycles after release=%0d", seen);
    endtask

    initial begin
        checks = 0; errors = 0;
        req_valid1 = 1'b0; req_op1 = 4'd0; req_a1 = 32'd0; req_b1 = 32'd0; req_cin1 = 1'b0;
        req_setflags1 = 1'b0; rsp_ready1 = 1'b0;
        req_valid3 = 1'b0; req_op3 = 4'd0; req_a3 = 32'd0; req_b3 = 32'd0; req_cin3 = 1'b0;
        req_setflags3 = 1'b0; rsp_ready3 = 1'b0;
        test_reset;
        test_flags;
        test_back_to_back;
        test_lat3;
        test_reset_abort;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
